acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_acc_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Sequences accumulator load/accumulate (128 writes from source RAM) and drain (128 reads) ops.
// Command handshake via acc_status with saturating timeout; drained stream has no backpressure.
module acc_sequencer #(
  parameter int ACK_TIMEOUT = 255,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  src_addr,
  input  logic [15:0] src_data_a,
  input  logic [15:0] src_data_b,
  output logic [3:0]  acc_cmd,
  input  logic [3:0]  acc_status,
  output logic        acc_readin,
  output logic        acc_readout,
  output logic [6:0]  acc_addr_a,
  output logic [6:0]  acc_addr_b,
  output logic [15:0] acc_data_a,
  output logic [15:0] acc_data_b,
  input  logic [6:0]  acc_addr_out,
  input  logic [15:0] acc_data_a_out,
  input  logic [15:0] acc_data_b_out,
  output logic        out_valid,
  output logic [6:0]  out_addr,
  output logic [15:0] out_data_a,
  output logic [15:0] out_data_b
);

  localparam int             TW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]     N_WORDS  = 8'd128;

  typedef enum logic [2:0] {IDLE, ACK, STREAM, DRAIN, CLOSE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [7:0]        cnt;
  logic [7:0]        out_cnt;
  logic [TW-1:0]     tmo;
  logic              iss;
  logic [RD_LAT-1:0] rd_pipe;
  logic              tmo_hit;

  assign tmo_hit = (tmo >= TMO_LAST);

  // Source RAM data lands the cycle after src_addr, the same cycle as the write strobe.
  assign acc_data_a = acc_readin ? src_data_a : '0;
  assign acc_data_b = acc_readin ? src_data_b : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= '0;
      cnt         <= '0;
      out_cnt     <= '0;
      tmo         <= '0;
      iss         <= 1'b0;
      rd_pipe     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      src_addr    <= '0;
      acc_cmd     <= '0;
      acc_readin  <= 1'b0;
      acc_readout <= 1'b0;
      acc_addr_a  <= '0;
      acc_addr_b  <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data_a  <= '0;
      out_data_b  <= '0;
    end else begin
      done       <= 1'b0;
      error      <= 1'b0;
      acc_readin <= 1'b0;

      rd_pipe[0] <= acc_readout;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      out_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        out_addr   <= acc_addr_out;
        out_data_a <= acc_data_a_out;
        out_data_b <= acc_data_b_out;
        out_cnt    <= out_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (op == 2'd0) begin
              error <= 1'b1;
            end else begin
              op_q    <= op;
              acc_cmd <= {2'b00, op};
              tmo     <= '0;
              busy    <= 1'b1;
              state   <= ACK;
            end
          end
        end

        ACK: begin
          if (acc_status == acc_cmd) begin
            cnt     <= 8'd1;
            out_cnt <= '0;
            tmo     <= '0;
            if (op_q == 2'd3) begin
              acc_readout <= 1'b1;
              state       <= DRAIN;
            end else begin
              src_addr <= '0;
              iss      <= 1'b1;
              state    <= STREAM;
            end
          end else if (tmo_hit) begin
            acc_cmd <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        STREAM: begin
          acc_readin <= iss;
          acc_addr_a <= src_addr;
          acc_addr_b <= src_addr;
          // cnt stops at 128 so the address never wraps back to 0 mid-operation.
          if (cnt < N_WORDS) begin
            src_addr <= cnt[6:0];
            cnt      <= cnt + 8'd1;
          end else begin
            iss      <= 1'b0;
            src_addr <= '0;
          end
          if (acc_readin && acc_addr_a == 7'd127) begin
            acc_cmd <= '0;
            tmo     <= '0;
            state   <= CLOSE;
          end
        end

        DRAIN: begin
          if (acc_readout) begin
            if (cnt == N_WORDS) acc_readout <= 1'b0;
            else                cnt         <= cnt + 8'd1;
          end
          if (out_valid && out_cnt == N_WORDS) begin
            acc_cmd <= '0;
            tmo     <= '0;
            state   <= CLOSE;
          end
        end

        CLOSE: begin
          if (acc_status == 4'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmo_hit) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a latency-1 source RAM and a 2-cycle-ack accumulator model.
module tb_acc_sequencer;

  localparam int ACK_TIMEOUT = 255;
  localparam int RD_LAT      = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        busy, done, error;
  logic [6:0]  src_addr;
  logic [15:0] src_data_a, src_data_b;
  logic [3:0]  acc_cmd, acc_status;
  logic        acc_readin, acc_readout;
  logic [6:0]  acc_addr_a, acc_addr_b;
  logic [15:0] acc_data_a, acc_data_b;
  logic [6:0]  acc_addr_out;
  logic [15:0] acc_data_a_out, acc_data_b_out;
  logic        out_valid;
  logic [6:0]  out_addr;
  logic [15:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  acc_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .busy(busy), .done(done), .error(error),
    .src_addr(src_addr), .src_data_a(src_data_a), .src_data_b(src_data_b),
    .acc_cmd(acc_cmd), .acc_status(acc_status),
    .acc_readin(acc_readin), .acc_readout(acc_readout),
    .acc_addr_a(acc_addr_a), .acc_addr_b(acc_addr_b),
    .acc_data_a(acc_data_a), .acc_data_b(acc_data_b),
    .acc_addr_out(acc_addr_out), .acc_data_a_out(acc_data_a_out), .acc_data_b_out(acc_data_b_out),
    .out_valid(out_valid), .out_addr(out_addr), .out_data_a(out_data_a), .out_data_b(out_data_b)
  );

  // Source RAM: registered read, word i holds {3i, 3i+1}.
  logic [6:0] src_q;
  always @(posedge clk) src_q <= src_addr;
  assign src_data_a = 16'(3 * src_q);
  assign src_data_b = 16'(3 * src_q + 1);

  // Accumulator: status follows cmd two cycles later when acking; reads return i+5 / 2i.
  logic       ack_en;
  logic [3:0] cmd_d1;
  logic [7:0] rd_idx;
  always @(posedge clk) begin
    cmd_d1     <= acc_cmd;
    acc_status <= ack_en ? cmd_d1 : 4'd0;
  end
  always @(posedge clk) begin
    if (!reset) rd_idx <= '0;
    else if (acc_readout) begin
      acc_addr_out   <= rd_idx[6:0];
      acc_data_a_out <= 16'(rd_idx + 5);
      acc_data_b_out <= 16'(2 * rd_idx);
      rd_idx         <= rd_idx + 8'd1;
    end
  end

  logic any_out;
  assign any_out = |{busy, done, error, src_addr, acc_cmd, acc_readin, acc_readout,
                     acc_addr_a, acc_addr_b, acc_data_a, acc_data_b,
                     out_valid, out_addr, out_data_a, out_data_b};

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int wr, rdo, ov, dn, er, bad, both;
  int first_wr, last_wr, first_rdo, last_rdo, err_cyc;
  logic [3:0] cmd0;
  logic       busy0;

  // Issue one op and observe until done/error plus a short tail; c counts cycles after the accepting edge.
  task automatic run_op(input logic [1:0] o, input bit inject);
    int tail;
    tail = -1;
    wr = 0; rdo = 0; ov = 0; dn = 0; er = 0; bad = 0; both = 0;
    first_wr = -1; last_wr = -1; first_rdo = -1; last_rdo = -1; err_cyc = -1;
    start = 1'b1;
    op    = o;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
        cmd0  = acc_cmd;
        busy0 = busy;
      end
      if (inject && acc_readin && acc_addr_a == 7'd40) begin
        start = 1'b1;
        op    = 2'd3;
      end
      if (acc_readin) begin
        if (acc_addr_a != 7'(wr) || acc_addr_b != 7'(wr) ||
            acc_data_a != 16'(3 * wr) || acc_data_b != 16'(3 * wr + 1)) bad++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        wr++;
      end
      if (acc_readout) begin
        if (first_rdo < 0) first_rdo = c;
        last_rdo = c;
        rdo++;
      end
      if (out_valid) begin
        if (out_addr != 7'(ov) || out_data_a != 16'(ov + 5) || out_data_b != 16'(2 * ov)) bad++;
        ov++;
      end
      if ((acc_readin && acc_readout) || (done && error)) both++;
      if (done) dn++;
      if (error) begin
        er++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (tail < 0 && (done || error)) tail = 4;
      else if (tail > 0) tail--;
      if (tail == 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int hit, noise;
    n_vec = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; op = 2'd0; ack_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_outputs", any_out, 0);

    // Load, started on the cycle reset is released.
    reset = 1'b1;
    run_op(2'd1, 1'b0);
    chk("load_cmd", cmd0, 1);
    chk("load_busy", busy0, 1);
    chk("load_first_write", first_wr, 4);
    chk("load_writes", wr, 128);
    chk("load_contig", last_wr - first_wr + 1, 128);
    chk("load_data", bad, 0);
    chk("load_done", dn, 1);
    chk("load_error", er, 0);
    chk("load_no_read", rdo, 0);
    chk("load_excl", both, 0);
    chk("load_cmd_end", acc_cmd, 0);
    chk("load_idle", busy, 0);

    // Drain.
    run_op(2'd3, 1'b0);
    chk("drain_cmd", cmd0, 3);
    chk("drain_reads", rdo, 128);
    chk("drain_contig", last_rdo - first_rdo + 1, 128);
    chk("drain_outs", ov, 128);
    chk("drain_data", bad, 0);
    chk("drain_done", dn, 1);
    chk("drain_no_write", wr, 0);
    chk("drain_excl", both, 0);

    // Accumulate with a start pulse while streaming.
    run_op(2'd2, 1'b1);
    chk("accum_cmd", cmd0, 2);
    chk("accum_writes", wr, 128);
    chk("accum_data", bad, 0);
    chk("accum_done", dn, 1);
    chk("accum_no_read", rdo, 0);
    chk("accum_error", er, 0);

    // Ack timeout.
    ack_en = 1'b0;
    run_op(2'd2, 1'b0);
    chk("tmo_error", er, 1);
    chk("tmo_cycle", err_cyc, ACK_TIMEOUT);
    chk("tmo_no_write", wr, 0);
    chk("tmo_no_done", dn, 0);
    chk("tmo_cmd", acc_cmd, 0);
    chk("tmo_idle", busy, 0);
    ack_en = 1'b1;
    repeat (3) @(negedge clk);

    // Illegal op.
    start = 1'b1; op = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_error", error, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_cmd", acc_cmd, 0);
    @(negedge clk);
    chk("illegal_pulse", error, 0);
    chk("illegal_busy2", busy, 0);

    // Reset in the middle of a load.
    hit = 0;
    start = 1'b1; op = 2'd1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (acc_readin && acc_addr_a == 7'd64) begin
        hit = 1;
        break;
      end
    end
    chk("rst_mid_reached", hit, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", any_out, 0);
    noise = 0;
    repeat (3) begin
      @(negedge clk);
      if (any_out) noise++;
    end
    chk("rst_mid_quiet", noise, 0);
    reset = 1'b1;
    run_op(2'd1, 1'b0);
    chk("rst_reload_writes", wr, 128);
    chk("rst_reload_data", bad, 0);
    chk("rst_reload_done", dn, 1);
    chk("rst_reload_error", er, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
